// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial, LSB-first two-operand adder. A single full-adder cell consumes
// one bit of each operand per clock. The carry between bit positions is held
// in a register. An N-bit add therefore takes WIDTH clocks instead of WIDTH
// parallel adder cells.
//
// Handshake:
//   * start is sampled only while idle.
//   * busy is high while bits are processed.
//   * done pulses for one cycle when sum/carry take a new value.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   * Adds a "sub" input that is captured together with the operands.
//   * With sub=1 the bit stream computes a + ~b + 1 = a - b.
//   * In that mode carry reports the borrow (the inverted carry-out).
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   operation request (idle only)
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   a      in   [WIDTH] operand A, captured on accepted start
//   b      in   [WIDTH] operand B, captured on accepted start
//   busy   out  operation in progress
//   done   out  one-cycle result-valid pulse
//   sum    out  [WIDTH] registered result, held until next completion
//   carry  out  registered carry-out (borrow in subtract mode)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Full-adder bit cell.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  // Only the upper WIDTH-1 result bits need storage. The final bit comes
  // straight from the adder cell on the completing edge.
  logic [WIDTH-2:0] sr_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q;
`endif

  logic             s_bit;
  logic             c_out;
  logic [WIDTH-1:0] sr_d;

  assign s_bit = fa_sum(sa_q[0], sb_q[0], c_q);
  assign c_out = fa_carry(sa_q[0], sb_q[0], c_q);
  // The new bit enters at the MSB. After WIDTH shifts, bit 0 of the operands
  // has reached bit 0 of the result.
  assign sr_d  = {s_bit, sr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q   <= a;
`ifdef SERIAL_ADDER_SUB_EN
            // a - b == a + ~b + 1; the +1 enters as the initial carry.
            sb_q   <= sub ? ~b : b;
            c_q    <= sub;
            sub_q  <= sub;
`else
            sb_q   <= b;
            c_q    <= 1'b0;
`endif
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_d[WIDTH-1:1];
          c_q   <= c_out;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= sr_d;
`ifdef SERIAL_ADDER_SUB_EN
            // In subtract mode a missing carry-out means a borrow occurred.
            carry_q <= sub_q ? ~c_out : c_out;
`else
            carry_q <= c_out;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=8).
//
// Stimulus and checking:
//   * Directed vectors are held in a table and checked against constants.
//   * Multi-cycle corner cases are hand-written sequences:
//       - ignored start while busy
//       - reset mid-operation
//       - back-to-back starts
//   * Random operations are checked against a plain-arithmetic model.
//
// Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  logic         sub_v;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_v),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned add with the carry as the 9th bit, or unsigned
  // subtract with the borrow set when a < b.
  function automatic logic [W:0] ref_op(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic s);
    int unsigned r;
    if (s) begin
      r = (int'(x) - int'(y)) & ((1 << W) - 1);
      return {(x < y), r[W-1:0]};
    end
    r = int'(x) + int'(y);
    return r[W:0];
  endfunction

  // Issue one operation and wait for done.
  // Returns the result and the number of edges from acceptance to done.
  // Also checks that busy stays high and sum stays stable while running.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output logic [W-1:0] rs, output logic rc,
                       output int lat);
    logic [W-1:0] held;
    logic         busy_ok;
    logic         hold_ok;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    held = sum;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (sum !== held) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("busy_during_run", 32'(busy_ok), 32'd1);
    check("sum_stable_run", 32'(hold_ok), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    rs = sum;
    rc = carry;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  logic [W-1:0] rs;
  logic         rc;
  int           lat;
  int           pulses;
  logic [W:0]   exp;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    sub_v = 1'b0;

    vecs.push_back('{8'h3C, 8'h15, 1'b0, 8'h51, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h3C, 8'h15, 1'b1, 8'h27, 1'b0});
    vecs.push_back('{8'h15, 8'h3C, 1'b1, 8'hD9, 1'b1});
    vecs.push_back('{8'h3C, 8'h3C, 1'b1, 8'h00, 1'b0});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      sub_v = vecs[i].vsub;
      do_op(vecs[i].va, vecs[i].vb, rs, rc, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(W));
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_carry", i), 32'(rc), 32'(vecs[i].exp_carry));
    end
    sub_v = 1'b0;

    // A start re-asserted while busy is ignored.
    @(negedge clk);
    start = 1'b1;
    a = 8'h3C;
    b = 8'h15;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        pulses++;
        check("busy_ign_sum", 32'(sum), 32'h51);
        check("busy_ign_carry", 32'(carry), 32'd0);
      end
      @(negedge clk);
    end
    check("busy_ign_pulses", 32'(pulses), 32'd1);

    // Reset mid-operation discards the operation and clears the outputs.
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    do_op(8'h01, 8'h02, rs, rc, lat);
    check("after_rst_sum", 32'(rs), 32'h03);
    check("after_rst_carry", 32'(rc), 32'd0);

    // Back-to-back: the second start is issued in the done cycle.
    @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_lat", 32'(lat), 32'(W));
    check("b2b_first_sum", 32'(sum), 32'h00);
    check("b2b_first_carry", 32'(carry), 32'd1);
    start = 1'b1;
    a = 8'h10;
    b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_gap", 32'(lat), 32'(W + 1));
    check("b2b_second_sum", 32'(sum), 32'h30);
    check("b2b_second_carry", 32'(carry), 32'd0);
    @(negedge clk);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub_v = 1'($urandom_range(0, 1));
`else
      sub_v = 1'b0;
`endif
      exp = ref_op(ra, rb, sub_v);
      do_op(ra, rb, rs, rc, lat);
      check("rand_lat", 32'(lat), 32'(W));
      check("rand_sum", 32'(rs), 32'(exp[W-1:0]));
      check("rand_carry", 32'(rc), 32'(exp[W]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Whole-run bound.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first two-operand adder built around a single full-adder bit cell and a registered carry.
- The arithmetic counterpart to the team's subtractor cells: serial addition instead of parallel subtraction.
- Trades latency for area: one bit per clock, start/busy/done handshake.
- Intended for datapaths where WIDTH parallel adder cells are too costly.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse marking a valid new result.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry  output  1  registered carry-out (borrow in subtract mode); holds with sum.

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, carry=0.
  - Reset also clears the internal shift registers, bit counter and carry flop.
  - An operation interrupted by reset is discarded; no done pulse is issued.
- FSM has two states, IDLE and RUN.
- IDLE:
  - On an edge with start=1: load a into shift reg SA and b into SB, clear carry flop c, counter=0, busy=1, go to RUN.
  - start=0 stays in IDLE.
- RUN, on each edge, using bit i = SA[0], SB[0]:
  - s_i = SA[0]^SB[0]^c.
  - c <= (SA[0]&SB[0]) | (SA[0]&c) | (SB[0]&c).
  - SA and SB shift right by 1.
  - s_i shifts into the MSB of an internal result shift register SR.
  - counter increments.
- Completion, on the edge processing bit WIDTH-1:
  - sum <= final SR value (including that bit).
  - carry <= final carry-out.
  - done <= 1, busy <= 0, go to IDLE.
- Latency: start accepted at edge 0 gives done=1 and a valid sum/carry after edge WIDTH; done clears after edge WIDTH+1.
- done is exactly one cycle wide. sum and carry are updated only at completion and remain stable at all other times.
- start while busy=1 is ignored; no queueing.
- a and b may change freely after the accepting edge.
- Back-to-back operation:
  - start high in the done cycle is accepted, since the FSM is already in IDLE.
  - The next result follows WIDTH cycles later; throughput is one result per WIDTH+1 cycles.
- Overflow: sum wraps modulo 2^WIDTH; the carry output is the unsigned overflow flag.
- Counter width is clog2(WIDTH)+1 bits.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands at start.
  - sub=1: SB is loaded with ~b and the carry flop is initialised to 1, giving sum = a - b mod 2^WIDTH.
  - The carry output reports borrow = ~carry-out (1 when a < b unsigned).
  - sub=0: identical to plain add.
- When undefined: no sub port; add only; carry flop always initialised to 0.

Test Plan:
1. WIDTH=8, a=0x3C, b=0x15, start 1 cycle -> busy for 8 cycles, then done pulse with sum=0x51, carry=0.
2. a=0xFF, b=0x01 -> sum=0x00, carry=1.
3. a=0x00, b=0x00 -> sum=0x00, carry=0.
4. Start a=0x3C, b=0x15; reassert start with a=0xFF, b=0xFF at cycle 3 -> second start ignored; result 0x51, single done pulse.
5. Start a=0xAA, b=0x55; assert rst at cycle 4 -> next cycle busy=0, sum=0x00, carry=0, no done pulse. Then a=0x01, b=0x02 -> sum=0x03.
6. Back-to-back:
   - Start a=0x80, b=0x80, then start again in the done cycle with a=0x10, b=0x20.
   - Expect first sum=0x00, carry=1.
   - Expect second done 9 cycles after the first, with sum=0x30, carry=0.
7. With SERIAL_ADDER_SUB_EN:
   - sub=1, a=0x3C, b=0x15 -> sum=0x27, carry(borrow)=0.
   - sub=1, a=0x15, b=0x3C -> sum=0xD9, borrow=1.
